// File: rtl/foc_stage_sequencer.sv
// rtl/foc_stage_sequencer.sv - captures one sample bundle per control cycle and sequences N_STAGES start/done stages
module foc_stage_sequencer #(
    parameter int  D_WIDTH  = 16,
    parameter int  N_CH     = 6,
    parameter int  N_STAGES = 6,
    parameter int  TIMEOUT  = 255,
    parameter int  CNT_W    = 16,
    localparam int IW       = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_CH*D_WIDTH-1:0]  in_data,
    output logic [N_CH*D_WIDTH-1:0]  smp_data,
    input  logic [N_STAGES-1:0]      stage_fixed,
    input  logic [N_STAGES-1:0]      stage_bypass,
    output logic [N_STAGES-1:0]      stage_start,
    input  logic [N_STAGES-1:0]      stage_done,
    output logic                     mod_clear,
    output logic                     cycle_done,
    output logic [CNT_W-1:0]         cycle_count,
    output logic                     busy,
    output logic                     fault,
    output logic [IW-1:0]            fault_stage,
    input  logic                     fault_clr
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_CLEAR  = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    state_t                state;
    logic [IW-1:0]         idx;
    logic [TW-1:0]         timer;
    logic [N_STAGES-1:0]   fixed_q;
    logic [N_STAGES-1:0]   bypass_q;
    logic                  fault_first;
    logic [IW:0]           first_hit;
    logic [IW:0]           succ_hit;
    logic                  advance;

    // Returns {found, index} of the lowest non-bypassed stage at or above 'from'.
    function automatic logic [IW:0] next_active(input logic [N_STAGES-1:0] byp, input int from);
        logic [IW:0] r;
        r = '0;
        for (int i = N_STAGES - 1; i >= 0; i--) begin
            if (i >= from && !byp[i]) r = {1'b1, IW'(i)};
        end
        return r;
    endfunction

    always_comb begin
        first_hit = next_active(stage_bypass, 0);
        succ_hit  = next_active(bypass_q, int'(idx) + 1);
        advance   = fixed_q[idx] | stage_done[idx];
    end

    assign in_ready    = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign cycle_done  = (state == S_CLEAR);
    assign mod_clear   = (state == S_CLEAR) || ((state == S_FAULT) && fault_first);
    assign stage_start = (state == S_LAUNCH) ? (N_STAGES'(1) << idx) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            timer       <= '0;
            fixed_q     <= '0;
            bypass_q    <= '0;
            fault_first <= 1'b0;
            smp_data    <= '0;
            cycle_count <= '0;
            fault       <= 1'b0;
            fault_stage <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        smp_data <= in_data;
                        fixed_q  <= stage_fixed;
                        bypass_q <= stage_bypass;
                        if (first_hit[IW]) begin
                            idx   <= first_hit[IW-1:0];
                            state <= S_LAUNCH;
                        end else begin
                            state <= S_CLEAR;
                        end
                    end
                end
                S_LAUNCH: begin
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (advance) begin
                        if (succ_hit[IW]) begin
                            idx   <= succ_hit[IW-1:0];
                            state <= S_LAUNCH;
                        end else begin
                            state <= S_CLEAR;
                        end
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        // This was the last permitted WAIT cycle without done.
                        fault       <= 1'b1;
                        fault_stage <= idx;
                        fault_first <= 1'b1;
                        state       <= S_FAULT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_CLEAR: begin
                    cycle_count <= cycle_count + 1'b1;
                    state       <= S_IDLE;
                end
                S_FAULT: begin
                    fault_first <= 1'b0;
                    if (fault_clr) begin
                        fault <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_foc_stage_sequencer.sv
// tb/tb_foc_stage_sequencer.sv - table-driven and randomized bench for foc_stage_sequencer
module tb_foc_stage_sequencer;

    localparam int DW  = 16;
    localparam int NCH = 6;
    localparam int NS  = 6;
    localparam int TO  = 4;
    localparam int CW  = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic                in_valid;
    logic                in_ready;
    logic [NCH*DW-1:0]   in_data;
    logic [NCH*DW-1:0]   smp_data;
    logic [NS-1:0]       stage_fixed;
    logic [NS-1:0]       stage_bypass;
    logic [NS-1:0]       stage_start;
    logic [NS-1:0]       stage_done;
    logic                mod_clear;
    logic                cycle_done;
    logic [CW-1:0]       cycle_count;
    logic                busy;
    logic                fault;
    logic [2:0]          fault_stage;
    logic                fault_clr;

    foc_stage_sequencer #(
        .D_WIDTH (DW),
        .N_CH    (NCH),
        .N_STAGES(NS),
        .TIMEOUT (TO),
        .CNT_W   (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .smp_data    (smp_data),
        .stage_fixed (stage_fixed),
        .stage_bypass(stage_bypass),
        .stage_start (stage_start),
        .stage_done  (stage_done),
        .mod_clear   (mod_clear),
        .cycle_done  (cycle_done),
        .cycle_count (cycle_count),
        .busy        (busy),
        .fault       (fault),
        .fault_stage (fault_stage),
        .fault_clr   (fault_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NS-1:0] start;
        logic [NS-1:0] done_drv;
        logic          mclr;
        logic          cdone;
        logic          flt;
        logic [2:0]    fstage;
    } step_t;

    typedef struct {
        logic [NS-1:0] fx;
        logic [NS-1:0] byp;
        logic [23:0]   dly;
        int            len;
        logic [NS-1:0] mask;
        bit            flt;
    } vec_t;

    int            vectors = 0;
    int            errors  = 0;
    int            cnt_model = 0;
    logic [NS-1:0] obs_mask;
    int            obs_len;
    bit            obs_fault;
    vec_t          tbl [8];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {in_ready, busy, stage_start, mod_clear, cycle_done, cycle_count, fault, fault_stage},
              {1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 4'h0, 1'b0, 3'h0});
        check({name, "_smp"}, smp_data, '0);
    endtask

    function automatic logic [NCH*DW-1:0] make_bundle();
        logic [NCH*DW-1:0] d;
        for (int ch = 0; ch < NCH; ch++) d[ch*DW +: DW] = (ch == 3) ? 16'h8001 : DW'($urandom);
        return d;
    endfunction

    // Builds the expected per-cycle schedule from the stage rules, drives the bundle and compares every cycle.
    task automatic run_cycle(input logic [NS-1:0] fx, input logic [NS-1:0] byp, input logic [23:0] dly,
                             input logic [NCH*DW-1:0] data, input bit noisy);
        step_t steps[$];
        step_t s;
        bit    faulted = 0;
        int    fst = 0;
        bit    seen = 0;
        for (int i = 0; i < NS; i++) begin
            int d;
            if (byp[i]) continue;
            d = int'(dly[i*4 +: 4]);
            s = '{default: '0};
            s.start = 6'(1 << i);
            s.done_drv = noisy ? 6'($urandom) : '0;
            steps.push_back(s);
            if (fx[i]) begin
                s = '{default: '0};
                s.done_drv = noisy ? 6'($urandom) : '0;
                steps.push_back(s);
            end else begin
                for (int w = 1; w <= TO && w <= d; w++) begin
                    s = '{default: '0};
                    s.done_drv = noisy ? (6'($urandom) & ~6'(1 << i)) : '0;
                    if (w == d) s.done_drv[i] = 1'b1;
                    steps.push_back(s);
                end
                if (d > TO) begin
                    s = '{default: '0};
                    s.done_drv = noisy ? 6'($urandom) : '0;
                    s.mclr = 1'b1;
                    s.flt = 1'b1;
                    s.fstage = 3'(i);
                    steps.push_back(s);
                    faulted = 1;
                    fst = i;
                    break;
                end
            end
        end
        if (!faulted) begin
            s = '{default: '0};
            s.mclr = 1'b1;
            s.cdone = 1'b1;
            steps.push_back(s);
        end

        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data = data;
        stage_fixed = fx;
        stage_bypass = byp;
        stage_done = noisy ? 6'($urandom) : '0;
        fault_clr = noisy ? 1'($urandom) : 1'b0;
        @(negedge clk);
        check("capture_ready", in_ready, 1'b1);

        obs_mask = '0;
        obs_len = 0;
        obs_fault = 0;
        foreach (steps[k]) begin
            @(posedge clk); #1;
            in_valid = noisy ? 1'($urandom) : 1'b0;
            if (noisy) begin
                in_data = {$urandom, $urandom, $urandom};
                stage_fixed = 6'($urandom);
                stage_bypass = 6'($urandom);
            end
            stage_done = steps[k].done_drv;
            fault_clr = steps[k].flt ? 1'b0 : (noisy ? 1'($urandom) : 1'b0);
            @(negedge clk);
            check($sformatf("step%0d", k), {stage_start, mod_clear, cycle_done, busy, in_ready, fault},
                  {steps[k].start, steps[k].mclr, steps[k].cdone, 1'b1, 1'b0, steps[k].flt});
            if (steps[k].flt) check("fault_stage", fault_stage, steps[k].fstage);
            obs_mask |= stage_start;
            if (!seen) obs_len++;
            if (cycle_done || fault) seen = 1;
            if (fault) obs_fault = 1;
        end

        if (faulted) begin
            for (int h = 0; h < 3; h++) begin
                @(posedge clk); #1;
                in_valid = 1'b1;
                in_data = {$urandom, $urandom, $urandom};
                stage_done = 6'($urandom);
                fault_clr = 1'b0;
                @(negedge clk);
                check("fault_hold", {in_ready, busy, fault, mod_clear, stage_start, fault_stage, cycle_count},
                      {1'b0, 1'b1, 1'b1, 1'b0, 6'h00, 3'(fst), 4'(cnt_model)});
            end
            @(posedge clk); #1;
            fault_clr = 1'b1;
            @(negedge clk);
            check("fault_clr_cycle", {in_ready, fault}, {1'b0, 1'b1});
            @(posedge clk); #1;
            fault_clr = 1'b0;
            in_valid = 1'b0;
            @(negedge clk);
            check("after_fault", {in_ready, busy, fault, fault_stage, cycle_count, mod_clear},
                  {1'b1, 1'b0, 1'b0, 3'(fst), 4'(cnt_model), 1'b0});
        end else begin
            cnt_model = (cnt_model + 1) % (1 << CW);
            @(posedge clk); #1;
            in_valid = 1'b0;
            fault_clr = 1'b0;
            stage_done = '0;
            @(negedge clk);
            check("end_idle", {in_ready, busy, cycle_done, mod_clear, cycle_count},
                  {1'b1, 1'b0, 1'b0, 1'b0, 4'(cnt_model)});
        end
        check("smp_data", smp_data, data);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [NCH*DW-1:0] data;
        logic [23:0]       dly;
        logic [NS-1:0]     byp;
        int                cnt0;

        tbl[0] = '{6'h3F, 6'h00, 24'h000000, 13, 6'h3F, 1'b0};
        tbl[1] = '{6'h3D, 6'h00, 24'h000030, 15, 6'h3F, 1'b0};
        tbl[2] = '{6'h3B, 6'h00, 24'h000500, 10, 6'h07, 1'b1};
        tbl[3] = '{6'h3F, 6'h0A, 24'h000000,  9, 6'h35, 1'b0};
        tbl[4] = '{6'h3F, 6'h3F, 24'h000000,  1, 6'h00, 1'b0};
        tbl[5] = '{6'h3E, 6'h00, 24'h000004, 16, 6'h3F, 1'b0};
        tbl[6] = '{6'h00, 6'h0A, 24'h111111,  9, 6'h35, 1'b0};
        tbl[7] = '{6'h1F, 6'h00, 24'h500000, 16, 6'h3F, 1'b1};

        reset = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        stage_fixed = '0;
        stage_bypass = '0;
        stage_done = '0;
        fault_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("post_reset");

        for (int r = 0; r < 8; r++) begin
            data = make_bundle();
            run_cycle(tbl[r].fx, tbl[r].byp, tbl[r].dly, data, 1'b1);
            check($sformatf("tbl%0d_len", r), obs_len, tbl[r].len);
            check($sformatf("tbl%0d_mask", r), obs_mask, tbl[r].mask);
            check($sformatf("tbl%0d_fault", r), obs_fault, tbl[r].flt);
        end

        cnt0 = cnt_model;
        for (int r = 0; r < 17; r++) begin
            data = make_bundle();
            run_cycle(6'($urandom), 6'h3F, 24'h0, data, 1'b1);
        end
        check("wrap_count", cycle_count, 4'((cnt0 + 17) % 16));
        check("wrap_ch3", smp_data[3*DW +: DW], 16'h8001);

        for (int r = 0; r < 50; r++) begin
            for (int i = 0; i < NS; i++)
                dly[i*4 +: 4] = ($urandom_range(0, 9) == 0) ? 4'(TO + 1) : 4'($urandom_range(1, TO));
            byp = ($urandom_range(0, 3) == 0) ? 6'($urandom) : (6'($urandom) & 6'($urandom));
            run_cycle(6'($urandom), byp, dly, {$urandom, $urandom, $urandom}, 1'b1);
        end

        data = make_bundle();
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data = data;
        stage_fixed = 6'h37;
        stage_bypass = 6'h00;
        stage_done = '0;
        fault_clr = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            stage_done = '0;
            @(negedge clk);
            if (k == 6) check("pre_reset_start3", stage_start, 6'h08);
        end
        check("pre_reset_wait", {busy, stage_start}, {1'b1, 6'h00});
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("midcycle_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        cnt_model = 0;
        run_cycle(6'h3F, 6'h00, 24'h0, make_bundle(), 1'b0);
        check("restart_len", obs_len, 13);
        check("restart_mask", obs_mask, 6'h3F);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/foc_stage_sequencer.md
Name: foc_stage_sequencer

Overview:
- Parametrised successor to the fixed FOC cycle controller.
- Captures one multi-channel sample bundle per control cycle, then drives N_STAGES downstream stages (clarke/cordic, park, pid, ipark, iclarke, svm) in order, each with a one-hot start/done handshake.
- Per-stage mode is runtime-selectable: wait-for-done, fixed single-cycle, or bypass.
- Adds what the fixed controller lacks: per-stage watchdog timeout, a sticky fault with stage index, a cycle counter, and a one-cycle clear pulse to the datapath modules at the end of every cycle.

Parameters:
- D_WIDTH, 16, width of each captured channel
- N_CH, 6, number of captured channels (angle, currA/B/C, currT, periodTop)
- N_STAGES, 6, number of sequenced stages
- TIMEOUT, 255, maximum WAIT cycles per stage before fault (must be ≥1)
- CNT_W, 16, width of cycle_count

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  sample bundle valid
- in_ready  out  1  sequencer can accept a bundle
- in_data  in  N_CH*D_WIDTH  sample bundle; channel k at bits [k*D_WIDTH +: D_WIDTH]
- smp_data  out  N_CH*D_WIDTH  registered captured bundle, held stable for the whole cycle
- stage_fixed  in  N_STAGES  1 = stage advances one cycle after start, stage_done ignored
- stage_bypass  in  N_STAGES  1 = stage skipped (bypass has priority over fixed)
- stage_start  out  N_STAGES  one-hot, one-cycle start pulse
- stage_done  in  N_STAGES  per-stage done
- mod_clear  out  1  one-cycle clear pulse to datapath modules
- cycle_done  out  1  one-cycle pulse, control cycle completed without fault
- cycle_count  out  CNT_W  completed-cycle counter, wraps
- busy  out  1  state != IDLE
- fault  out  1  sticky stage timeout flag
- fault_stage  out  $clog2(N_STAGES)  index of the stage that timed out
- fault_clr  in  1  clears fault; honoured only in FAULT

Behaviour:
- Reset (asynchronous, active-high, any time including mid-cycle):
  - state=IDLE; smp_data, stage_start, mod_clear, cycle_done, cycle_count, fault, fault_stage = 0.
  - in_ready = 1, since in_ready = (state==IDLE).
- States: IDLE, LAUNCH, WAIT, CLEAR, FAULT; idx register holds the current stage.
- IDLE:
  - When in_valid && in_ready at edge T: latch in_data→smp_data, and latch stage_fixed/stage_bypass into internal mode registers. Mode changes mid-cycle are therefore ignored.
  - idx = lowest non-bypassed stage; next state LAUNCH. If all stages are bypassed, next state CLEAR.
- LAUNCH (one cycle): stage_start[idx]=1, all other bits 0; timer cleared; next state WAIT. stage_done is not sampled in LAUNCH.
- WAIT, each cycle:
  - Fixed stage: advance unconditionally.
  - Otherwise, if stage_done[idx]=1: advance.
  - Otherwise timer increments. If stage_done is absent for TIMEOUT consecutive WAIT cycles, next state FAULT. Done arriving in WAIT cycle number TIMEOUT is still accepted.
  - stage_done bits other than idx are ignored.
- Advance:
  - idx = next higher non-bypassed stage, then LAUNCH.
  - If none remain, go to CLEAR.
- CLEAR (one cycle): mod_clear=1, cycle_done=1, cycle_count += 1 modulo 2^CNT_W; next state IDLE.
- FAULT:
  - On entry edge: fault=1, fault_stage=idx; mod_clear=1 during the first FAULT cycle only.
  - in_ready=0 while in FAULT; cycle_count is not incremented.
  - fault_clr=1 → fault=0, fault_stage unchanged, next state IDLE.
  - fault_clr outside FAULT has no effect.
- stage_start and mod_clear are decoded from registered state and are glitch-free at the cycle level.
- Latency:
  - Capture at edge T → first stage_start visible in cycle T+1.
  - Each fixed stage costs 2 cycles; a done stage costs 1 + d cycles, where done is seen in WAIT cycle d.
  - For N active fixed stages: CLEAR in cycle T+1+2N; in_ready high again in cycle T+2+2N.
- in_valid while busy: not accepted, no effect; the upstream source holds the bundle.

Test Plan:
- Reset, then all 6 stages fixed, capture at T → stage_start one-hot 000001..100000 in cycles T+1, T+3, …, T+11; mod_clear and cycle_done in T+13; cycle_count=1; in_ready=1 in T+14.
- Stage 1 waits for done, raised in its 3rd WAIT cycle; other stages fixed → stage 2 start delayed by 2 cycles relative to the all-fixed run; stage_done[3] pulsed during stage 1 has no effect.
- TIMEOUT=4, stage 2 in done mode with done never asserted → fault=1, fault_stage=2 after 4 WAIT cycles; mod_clear for 1 cycle; in_ready=0 and in_valid ignored until fault_clr; cycle_count unchanged; then IDLE.
- stage_bypass=6'b001010 → starts issued only on stages 0, 2, 4, 5; toggling stage_bypass mid-cycle has no effect until the next capture; stage_bypass=6'b111111 → CLEAR one cycle after capture.
- CNT_W=4, run 17 cycles → cycle_count wraps 15→0→1; smp_data equals the bundle of the last capture, channel 3 = 16'h8001 preserved bit-exact.
- reset asserted while in WAIT of stage 3 → same-cycle return to IDLE with all outputs at reset values; a new capture restarts at stage 0.
